snake_game_core: RTL and testbench

SNAKE_GAME_CORE -- requirements
Module: snake_game_core

---
 rtl/snake_game_core.sv | 157 +++++++++++++++
 tb/tb_snake_game_core.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_game_core.sv
// snake_game_core: snake game state machine with apple placement and per-cell query
// Ports: hwclk/nrst clock and async active-low reset; start begins or restarts a game;
//   dir_valid/dir steer the snake (00 up, 01 down, 10 left, 11 right);
//   apple_x/apple_y offer a candidate apple cell; query_x/query_y select a cell to classify
//   into is_head/is_body/is_apple/is_border; apple_eaten pulses after a growth step;
//   game_over/game_won/length/state report game status.
// Build option: define SNAKE_WRAP_EN to wrap through the border instead of colliding with it.
module snake_game_core #(
  parameter int GRID_W   = 16,
  parameter int GRID_H   = 12,
  parameter int CW       = 4,
  parameter int MAX_LEN  = 32,
  parameter int TICK_DIV = 4
) (
  input  logic                         hwclk,
  input  logic                         nrst,
  input  logic                         start,
  input  logic                         dir_valid,
  input  logic [1:0]                   dir,
  input  logic [CW-1:0]                apple_x,
  input  logic [CW-1:0]                apple_y,
  input  logic [CW-1:0]                query_x,
  input  logic [CW-1:0]                query_y,
  output logic                         is_head,
  output logic                         is_body,
  output logic                         is_apple,
  output logic                         is_border,
  output logic                         apple_eaten,
  output logic                         game_over,
  output logic                         game_won,
  output logic [$clog2(MAX_LEN+1)-1:0] length,
  output logic [1:0]                   state
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] XMAX = CW'(GRID_W - 1);
  localparam logic [CW-1:0] YMAX = CW'(GRID_H - 1);
  localparam logic [CW-1:0] HX0 = CW'(GRID_W / 2);
  localparam logic [CW-1:0] HY0 = CW'(GRID_H / 2);
  localparam logic [LW-1:0] LMAX = LW'(MAX_LEN);
  localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);
  localparam logic [1:0] UP = 2'b00, DN = 2'b01, LT = 2'b10, RT = 2'b11;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, OVER = 2'b10, WIN = 2'b11} st_t;
  st_t st, st_nx;
  logic [CW-1:0] seg_x [MAX_LEN];
  logic [CW-1:0] seg_y [MAX_LEN];
  logic [CW-1:0] ax, ay, rx, ry, nx, ny;
  logic [1:0] cur, pend, eff;
  logic [TW-1:0] cnt;
  logic apple_ok, step, edge_hit, body_hit, crash, grow, cand_ok, occ;

  function automatic logic on_edge(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return x == '0 || x == XMAX || y == '0 || y == YMAX;
  endfunction

  function automatic logic [CW-1:0] init_x(input int i);
    return i < 3 ? HX0 - CW'(i) : '0;
  endfunction

  function automatic logic [CW-1:0] init_y(input int i);
    return i < 3 ? HY0 : '0;
  endfunction

  assign step = st == RUN && cnt == TLAST && !start;
  // a request arriving on a step cycle is judged against the direction about to take effect
  assign eff = step ? pend : cur;
  assign rx = pend == LT ? seg_x[0] - CW'(1) : pend == RT ? seg_x[0] + CW'(1) : seg_x[0];
  assign ry = pend == UP ? seg_y[0] - CW'(1) : pend == DN ? seg_y[0] + CW'(1) : seg_y[0];
`ifdef SNAKE_WRAP_EN
  assign nx = rx == '0 ? XMAX - CW'(1) : rx == XMAX ? CW'(1) : rx;
  assign ny = ry == '0 ? YMAX - CW'(1) : ry == YMAX ? CW'(1) : ry;
  assign edge_hit = 1'b0;
`else
  assign nx = rx;
  assign ny = ry;
  assign edge_hit = on_edge(rx, ry);
`endif

  // the tail segment (length-1) vacates on the step, so it is excluded from the self-hit test
  always_comb begin
    body_hit = 1'b0;
    occ = 1'b0;
    is_body = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      body_hit |= LW'(i) + LW'(1) < length && seg_x[i] == nx && seg_y[i] == ny;
      occ |= LW'(i) < length && seg_x[i] == apple_x && seg_y[i] == apple_y;
      is_body |= i > 0 && LW'(i) < length && seg_x[i] == query_x && seg_y[i] == query_y;
    end
  end

  assign crash = edge_hit || body_hit;
  assign grow = apple_ok && nx == ax && ny == ay && !crash;
  assign cand_ok = apple_x != '0 && apple_x < XMAX && apple_y != '0 && apple_y < YMAX && !occ;

  always_ff @(posedge hwclk or negedge nrst) begin
    if (!nrst) st <= IDLE;
    else st <= st_nx;
  end

  always_comb begin
    st_nx = start ? RUN : !step ? st : crash ? OVER : grow && length + LW'(1) == LMAX ? WIN : st;
  end

  always_ff @(posedge hwclk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= init_x(i);
        seg_y[i] <= init_y(i);
      end
      length <= LW'(3);
      cur <= RT;
      pend <= RT;
      apple_ok <= 1'b0;
      ax <= '0;
      ay <= '0;
      cnt <= '0;
      apple_eaten <= 1'b0;
    end else begin
      cnt <= st == RUN && !start && cnt != TLAST ? cnt + TW'(1) : '0;
      apple_eaten <= step && grow;
      if (dir_valid && !(dir[1] == eff[1] && dir[0] != eff[0])) pend <= dir;
      if (start) begin
        for (int i = 0; i < MAX_LEN; i++) begin
          seg_x[i] <= init_x(i);
          seg_y[i] <= init_y(i);
        end
        length <= LW'(3);
        cur <= RT;
        pend <= RT;
        apple_ok <= 1'b0;
      end else if (step && !crash) begin
        seg_x[0] <= nx;
        seg_y[0] <= ny;
        for (int i = 1; i < MAX_LEN; i++) begin
          seg_x[i] <= seg_x[i-1];
          seg_y[i] <= seg_y[i-1];
        end
        cur <= pend;
        if (grow) begin
          length <= length + LW'(1);
          apple_ok <= 1'b0;
        end
      end else if (st == RUN && !step && !apple_ok && cand_ok) begin
        apple_ok <= 1'b1;
        ax <= apple_x;
        ay <= apple_y;
      end
    end
  end

  assign is_head = query_x == seg_x[0] && query_y == seg_y[0];
  assign is_apple = apple_ok && query_x == ax && query_y == ay;
  assign is_border = on_edge(query_x, query_y);
  assign game_over = st == OVER;
  assign game_won = st == WIN;
  assign state = st;
endmodule

// File: tb/tb_snake_game_core.sv
// tb_snake_game_core: directed and random stimulus checked against a queue-based snake model
module tb_snake_game_core;
  localparam int GW = 16, GH = 12, ML = 32, TD = 4;
  logic hwclk = 1'b0, nrst = 1'b0, start = 1'b0, dir_valid = 1'b0;
  logic [1:0] dir = 2'b00;
  logic [3:0] apple_x = '0, apple_y = '0, query_x = '0, query_y = '0;
  logic is_head, is_body, is_apple, is_border, apple_eaten, game_over, game_won;
  logic [5:0] length;
  logic [1:0] state;
  int n_vec = 0, n_err = 0;
  int m_state, m_cnt, m_cur, m_pend, m_ax, m_ay, m_steps = 0;
  bit m_av, m_eaten;
  int sx[$], sy[$];

  snake_game_core #(.GRID_W(GW), .GRID_H(GH), .CW(4), .MAX_LEN(ML), .TICK_DIV(TD)) dut (
    .hwclk(hwclk), .nrst(nrst), .start(start), .dir_valid(dir_valid), .dir(dir),
    .apple_x(apple_x), .apple_y(apple_y), .query_x(query_x), .query_y(query_y),
    .is_head(is_head), .is_body(is_body), .is_apple(is_apple), .is_border(is_border),
    .apple_eaten(apple_eaten), .game_over(game_over), .game_won(game_won),
    .length(length), .state(state)
  );

  always #5 hwclk = ~hwclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void m_reset();
    sx = '{GW / 2, GW / 2 - 1, GW / 2 - 2};
    sy = '{GH / 2, GH / 2, GH / 2};
    m_state = 0;
    m_cnt = 0;
    m_cur = 3;
    m_pend = 3;
    m_av = 0;
    m_eaten = 0;
  endfunction

  function automatic bit on_snake(int x, int y, int n);
    for (int i = 0; i < n; i++) if (sx[i] == x && sy[i] == y) return 1;
    return 0;
  endfunction

  function automatic bit interior(int x, int y);
    return x >= 1 && x <= GW - 2 && y >= 1 && y <= GH - 2;
  endfunction

  function automatic void m_tick();
    int hx, hy, eff, np;
    bit was_run, is_step, hit;
    if (start) begin
      m_reset();
      m_state = 1;
      return;
    end
    was_run = m_state == 1;
    is_step = was_run && m_cnt == TD - 1;
    eff = is_step ? m_pend : m_cur;
    np = (dir_valid && ((int'(dir) ^ eff) != 1)) ? int'(dir) : m_pend;
    m_eaten = 0;
    if (is_step) begin
      hx = sx[0] + (m_pend == 3 ? 1 : m_pend == 2 ? -1 : 0);
      hy = sy[0] + (m_pend == 1 ? 1 : m_pend == 0 ? -1 : 0);
`ifdef SNAKE_WRAP_EN
      if (hx == 0) hx = GW - 2; else if (hx == GW - 1) hx = 1;
      if (hy == 0) hy = GH - 2; else if (hy == GH - 1) hy = 1;
      hit = 0;
`else
      hit = !interior(hx, hy);
`endif
      if (on_snake(hx, hy, sx.size() - 1)) hit = 1;
      m_steps++;
      if (hit) m_state = 2;
      else begin
        sx.push_front(hx);
        sy.push_front(hy);
        m_cur = m_pend;
        if (m_av && hx == m_ax && hy == m_ay) begin
          m_av = 0;
          m_eaten = 1;
          if (sx.size() == ML) m_state = 3;
        end else begin
          void'(sx.pop_back());
          void'(sy.pop_back());
        end
      end
    end else if (was_run && !m_av && interior(int'(apple_x), int'(apple_y)) &&
                 !on_snake(int'(apple_x), int'(apple_y), sx.size())) begin
      m_av = 1;
      m_ax = int'(apple_x);
      m_ay = int'(apple_y);
    end
    m_cnt = was_run && !is_step ? m_cnt + 1 : 0;
    m_pend = np;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic qchk(input int x, input int y);
    query_x = x[3:0];
    query_y = y[3:0];
    #1;
    chk("q_head", 32'(is_head), 32'(sx[0] == x && sy[0] == y));
    chk("q_body", 32'(is_body), 32'(on_snake(x, y, sx.size()) && !(sx[0] == x && sy[0] == y)));
    chk("q_apple", 32'(is_apple), 32'(m_av && m_ax == x && m_ay == y));
    chk("q_border", 32'(is_border), 32'(x == 0 || x == GW - 1 || y == 0 || y == GH - 1));
  endtask

  task automatic pin(input string tag, input int x, input int y, input logic [3:0] exp);
    query_x = x[3:0];
    query_y = y[3:0];
    #1;
    chk(tag, 32'({is_head, is_body, is_apple, is_border}), 32'(exp));
  endtask

  task automatic cycle();
    int k;
    m_tick();
    @(posedge hwclk);
    #1;
    chk("state", 32'(state), 32'(m_state));
    chk("length", 32'(length), 32'(sx.size()));
    chk("apple_eaten", 32'(apple_eaten), 32'(m_eaten));
    chk("game_over", 32'(game_over), 32'(m_state == 2));
    chk("game_won", 32'(game_won), 32'(m_state == 3));
    case ($urandom_range(0, 3))
      0, 1: qchk($urandom_range(0, 15), $urandom_range(0, 15));
      2: qchk(sx[0], sy[0]);
      default: begin
        k = $urandom_range(0, sx.size() - 1);
        if (m_av) qchk(m_ax, m_ay); else qchk(sx[k], sy[k]);
      end
    endcase
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic steps(input int n);
    int target = m_steps + n;
    int budget = 100;
    while (m_steps < target && budget > 0) begin
      cycle();
      budget--;
    end
    chk("step_budget", 32'(m_steps >= target), 32'd1);
  endtask

  task automatic begin_game();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic offer(input int x, input int y);
    apple_x = x[3:0];
    apple_y = y[3:0];
    cycle();
    apple_x = '0;
    apple_y = '0;
  endtask

  task automatic steer(input logic [1:0] d);
    dir_valid = 1'b1;
    dir = d;
    cycle();
    dir_valid = 1'b0;
  endtask

  initial begin
    m_reset();
    #12;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_length", 32'(length), 32'd3);
    chk("rst_flags", 32'({apple_eaten, game_over, game_won}), 32'd0);
    pin("rst_head", 8, 6, 4'b1000);
    pin("rst_seg1", 7, 6, 4'b0100);
    pin("rst_seg2", 6, 6, 4'b0100);
    nrst = 1'b1;
    run(3);
    // straight run into the right-hand border
    begin_game();
    run(28);
`ifdef SNAKE_WRAP_EN
    chk("wrap_state", 32'(state), 32'd1);
    chk("wrap_over", 32'(game_over), 32'd0);
    pin("wrap_head", 1, 6, 4'b1000);
`else
    chk("wall_state", 32'(state), 32'd2);
    chk("wall_over", 32'(game_over), 32'd1);
    pin("wall_head", 14, 6, 4'b1000);
    run(6);
    pin("wall_frozen", 14, 6, 4'b1000);
`endif
    pin("border_15_6", 15, 6, 4'b0001);
    // reversal request is ignored, a turn is honoured
    begin_game();
    steer(2'b10);
    run(3);
    pin("reverse_ignored", 9, 6, 4'b1000);
    begin_game();
    steer(2'b00);
    run(3);
    pin("turn_up", 8, 5, 4'b1000);
    // apple acceptance, growth and rejection of an occupied cell
    begin_game();
    offer(10, 6);
    pin("apple_taken", 10, 6, 4'b0010);
    steps(2);
    chk("grow_eaten", 32'(apple_eaten), 32'd1);
    chk("grow_length", 32'(length), 32'd4);
    offer(9, 6);
    chk("eaten_pulse_end", 32'(apple_eaten), 32'd0);
    pin("occupied_rejected", 9, 6, 4'b0100);
    offer(3, 3);
    pin("apple_3_3", 3, 3, 4'b0010);
    // self collision at length 5
    begin_game();
    offer(10, 6);
    steps(2);
    offer(11, 6);
    steps(1);
    chk("len5", 32'(length), 32'd5);
    steer(2'b00);
    steps(1);
    steer(2'b10);
    steps(1);
    steer(2'b01);
    steps(1);
    chk("self_over", 32'(game_over), 32'd1);
    chk("self_len", 32'(length), 32'd5);
    pin("self_head", 10, 5, 4'b1000);
    // asynchronous reset in the middle of a game
    begin_game();
    offer(10, 6);
    steps(2);
    offer(11, 6);
    steps(1);
    offer(12, 6);
    steps(1);
    chk("len6", 32'(length), 32'd6);
    run(2);
    #2 nrst = 1'b0;
    #1;
    m_reset();
    chk("mid_rst_len", 32'(length), 32'd3);
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_flags", 32'({apple_eaten, game_over, game_won}), 32'd0);
    pin("mid_rst_head", 8, 6, 4'b1000);
    #1 nrst = 1'b1;
    run(2);
    // random play with restarts
    begin_game();
    for (int c = 0; c < 2500; c++) begin
      dir_valid = $urandom_range(0, 3) == 0;
      dir = 2'($urandom_range(0, 3));
      apple_x = 4'($urandom_range(0, 15));
      apple_y = 4'($urandom_range(0, 15));
      start = (m_state >= 2 && $urandom_range(0, 7) == 0) || $urandom_range(0, 599) == 0;
      cycle();
    end
    start = 1'b0;
    dir_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
